// File: rtl/uart_rx_fsm_if.sv
// uart_rx_fsm_if: serial line in, recovered word and status strobes out.
// master drives the line and consumes words; slave is the receiver.
interface uart_rx_fsm_if #(
   parameter int F_SIZE = 8
);
   logic              rx_i;
   logic [F_SIZE-1:0] rx_data;
   logic              valid_o;
   logic              frame_err_o;
   logic              busy_o;

   modport master (
      output rx_i,
      input  rx_data,
      input  valid_o,
      input  frame_err_o,
      input  busy_o
   );

   modport slave (
      input  rx_i,
      output rx_data,
      output valid_o,
      output frame_err_o,
      output busy_o
   );
endinterface

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: UART receiver with 2-flop synchronizer, mid-bit sampling,
// framing-error strobe and break lockout until the line returns high.
module uart_rx_fsm #(
   parameter int F_SIZE       = 8,
   parameter int CLKS_PER_BIT = 1,
   parameter int BC_SIZE      = $clog2(F_SIZE) + 1
) (
   input logic          clk,
   input logic          rst,
   uart_rx_fsm_if.slave bus
);
   localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int HALF = (CLKS_PER_BIT - 1) / 2;

   localparam logic [CW-1:0]      HALF_C   = CW'(HALF);
   localparam logic [CW-1:0]      LAST_C   = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]      ONE_C    = CW'(1);
   localparam logic [BC_SIZE-1:0] BIT_LAST = BC_SIZE'(F_SIZE - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t              state;
   logic                sync1;
   logic                sync2;
   logic                armed;
   logic [CW-1:0]       clk_cnt;
   logic [BC_SIZE-1:0]  bit_cnt;
   logic [F_SIZE-1:0]   shreg;
   logic [F_SIZE-1:0]   rx_data_q;
   logic                valid_q;
   logic                ferr_q;
   logic                busy_q;
   logic                rx_s;

   assign rx_s            = sync2;
   assign bus.rx_data     = rx_data_q;
   assign bus.valid_o     = valid_q;
   assign bus.frame_err_o = ferr_q;
   assign bus.busy_o      = busy_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         sync1     <= 1'b1;
         sync2     <= 1'b1;
         armed     <= 1'b1;
         clk_cnt   <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         rx_data_q <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         sync1   <= bus.rx_i;
         sync2   <= sync1;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         unique case (state)
            IDLE: begin
               clk_cnt <= '0;
               bit_cnt <= '0;
               if (rx_s) begin
                  armed <= 1'b1;
               end else if (armed) begin
                  busy_q <= 1'b1;
                  // with HALF=0 the detection sample is the start check
                  if (HALF == 0) begin
                     state <= DATA;
                  end else begin
                     state   <= START;
                     clk_cnt <= ONE_C;
                  end
               end
            end
            START: begin
               bit_cnt <= '0;
               if (clk_cnt == HALF_C) begin
                  clk_cnt <= '0;
                  if (rx_s) begin
                     state  <= IDLE;
                     busy_q <= 1'b0;
                  end else begin
                     state <= DATA;
                  end
               end else begin
                  clk_cnt <= clk_cnt + ONE_C;
               end
            end
            DATA: begin
               if (clk_cnt == LAST_C) begin
                  clk_cnt <= '0;
                  shreg   <= {rx_s, shreg[F_SIZE-1:1]};
                  if (bit_cnt == BIT_LAST) begin
                     bit_cnt <= '0;
                     state   <= STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else begin
                  clk_cnt <= clk_cnt + ONE_C;
               end
            end
            STOP: begin
               bit_cnt <= '0;
               if (clk_cnt == LAST_C) begin
                  clk_cnt <= '0;
                  state   <= IDLE;
                  busy_q  <= 1'b0;
                  if (rx_s) begin
                     rx_data_q <= shreg;
                     valid_q   <= 1'b1;
                  end else begin
                     // a held-low break must go high before re-arming
                     ferr_q <= 1'b1;
                     armed  <= 1'b0;
                  end
               end else begin
                  clk_cnt <= clk_cnt + ONE_C;
               end
            end
            default: begin
               state   <= IDLE;
               busy_q  <= 1'b0;
               clk_cnt <= '0;
               bit_cnt <= '0;
            end
         endcase
      end
   end
endmodule
